uart_tx_feeder: RTL and testbench

//  Buffered front end for the UART transmitter. Accepts bytes from the system side over a valid/ready

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_feeder.sv | 85 ++++++++
 tb/tb_uart_tx_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM encodings and default sizes.
package uart_pkg;

  localparam int NB_DATA_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_START = 2'd1,
    FEED_WAIT  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and flags; head entry is read combinationally.
module sync_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_head,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count_next;
  logic               push_ok;
  logic               pop_ok;

  // Guarded locally so a careless caller can never corrupt the pointers.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    count_next = o_count + {{NB_ADDR{1'b0}}, push_ok} - {{NB_ADDR{1'b0}}, pop_ok};
  end

  // count never exceeds DEPTH, so its MSB alone marks full.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      o_count <= count_next;
      o_full  <= count_next[NB_ADDR];
      o_empty <= (count_next == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  assign o_head = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered front end for uart_tx: queues system bytes and issues them one at a time
// as a start pulse with held data, waiting for tx_done between bytes.
//  state      | meaning
//  FEED_IDLE  | no byte in flight; pops the head when the FIFO is not empty
//  FEED_START | one-cycle start pulse to uart_tx, data already registered
//  FEED_WAIT  | data held until uart_tx reports done
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int  NB_DATA    = NB_DATA_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int NB_ADDR    = $clog2(FIFO_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr_valid,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic               o_wr_ready,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done,
  output logic [NB_ADDR:0]   o_fifo_count,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_busy
);

  feed_state_t        state;
  feed_state_t        state_next;
  logic               push;
  logic               pop;
  logic [NB_DATA-1:0] head;

  assign o_wr_ready = !o_full;
  assign push       = i_wr_valid && o_wr_ready;
  assign o_busy     = (state != FEED_IDLE);

  sync_fifo #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_wr_data),
    .o_head  (head),
    .o_count (o_fifo_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    o_tx_start = 1'b0;
    case (state)
      FEED_IDLE: begin
        if (!o_empty) begin
          pop        = 1'b1;
          state_next = FEED_START;
        end
      end
      FEED_START: begin
        o_tx_start = 1'b1;
        state_next = FEED_WAIT;
      end
      FEED_WAIT: begin
        if (i_tx_done) state_next = FEED_IDLE;
      end
      default: state_next = FEED_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= FEED_IDLE;
      o_tx_data <= '0;
    end else begin
      state <= state_next;
      if (pop) o_tx_data <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder with a uart_tx responder and a queue model.
module tb_uart_tx_feeder;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done;
  logic [4:0] o_fifo_count;
  logic       o_full;
  logic       o_empty;
  logic       o_busy;

  logic done_resp  = 1'b0;
  logic done_stray = 1'b0;
  assign i_tx_done = done_resp | done_stray;

  int checks = 0;
  int errors = 0;

  uart_tx_feeder dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr_valid   (i_wr_valid),
    .i_wr_data    (i_wr_data),
    .o_wr_ready   (o_wr_ready),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .i_tx_done    (i_tx_done),
    .o_fifo_count (o_fifo_count),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: done pulses resp_n cycles after each observed start.
  bit resp_en = 1'b0;
  int resp_n  = 50;
  int resp_cnt = 0;
  always @(posedge i_clk) begin
    #1;
    done_resp = 1'b0;
    if (!o_busy) resp_cnt = 0;
    else if (o_tx_start) resp_cnt = resp_en ? resp_n : 0;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) done_resp = 1'b1;
    end
  end

  // Model: queue of accepted-but-not-started bytes; one byte in flight from start to done.
  bit         mon_en    = 1'b0;
  logic [7:0] exp_q[$];
  bit         in_flight = 1'b0;
  bit         exp_start = 1'b0;
  logic [7:0] held      = 8'h00;
  logic [7:0] exp_byte;

  always @(negedge i_clk) begin
    if (mon_en) begin
      check("start_timing", o_tx_start, exp_start);
      if (o_tx_start) begin
        check("start_with_data_queued", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_byte = exp_q.pop_front();
          check("tx_data_order", o_tx_data, exp_byte);
        end
        held      = o_tx_data;
        in_flight = 1'b1;
      end
      check("busy", o_busy, in_flight);
      if (in_flight) check("tx_data_held", o_tx_data, held);
      check("fifo_count", o_fifo_count, exp_q.size());
      check("full", o_full, exp_q.size() == 16);
      check("empty", o_empty, exp_q.size() == 0);
      check("wr_ready", o_wr_ready, exp_q.size() != 16);
      if (i_reset) begin
        exp_q.delete();
        in_flight = 1'b0;
        exp_start = 1'b0;
      end else begin
        exp_start = !in_flight && (exp_q.size() != 0);
        if (in_flight && !o_tx_start && i_tx_done) in_flight = 1'b0;
        if (i_wr_valid && o_wr_ready) exp_q.push_back(i_wr_data);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    i_wr_valid = 1'b1;
    i_wr_data  = b;
    forever begin
      @(negedge i_clk);
      if (o_wr_ready) break;
      t++;
      if (t > 5000) break;
    end
    check("push_timeout", t > 5000, 0);
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic wait_drained(input int limit);
    int t = 0;
    forever begin
      @(negedge i_clk);
      if (o_empty && !o_busy) break;
      t++;
      if (t > limit) break;
    end
    check("drain_timeout", t > limit, 0);
    tick();
  endtask

  task automatic pulse_stray_done();
    done_stray = 1'b1;
    tick();
    done_stray = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset    = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'h00;

    // 1. reset values, then a quiet idle period watched by the monitor
    repeat (3) tick();
    i_reset = 1'b0;
    mon_en  = 1'b1;
    @(negedge i_clk);
    check("rst_wr_ready", o_wr_ready, 1);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_count", o_fifo_count, 0);
    check("rst_full", o_full, 0);
    check("rst_empty", o_empty, 1);
    check("rst_busy", o_busy, 0);
    repeat (20) tick();

    // 2. single byte latency and hold
    resp_en    = 1'b1;
    resp_n     = 50;
    i_wr_valid = 1'b1;
    i_wr_data  = 8'hA5;
    tick();
    i_wr_valid = 1'b0;
    @(negedge i_clk);
    check("single_no_start_yet", o_tx_start, 0);
    check("single_count_1", o_fifo_count, 1);
    @(negedge i_clk);
    check("single_start", o_tx_start, 1);
    check("single_data", o_tx_data, 8'hA5);
    @(negedge i_clk);
    check("single_start_pulse_end", o_tx_start, 0);
    check("single_busy", o_busy, 1);
    wait_drained(200);
    check("single_data_after_done", o_tx_data, 8'hA5);

    // 3. fill to full with a slow responder
    resp_n = 500;
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    @(negedge i_clk);
    check("fill_full", o_full, 1);
    check("fill_wr_ready", o_wr_ready, 0);
    check("fill_count", o_fifo_count, 16);
    tick();
    push_byte(8'h11);
    wait_drained(15000);

    // 4. push on the same edge as the idle pop keeps the count
    resp_en = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    repeat (3) tick();
    check("pp_count_before", o_fifo_count, 5);
    done_stray = 1'b1;
    tick();
    done_stray = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h5C;
    resp_en    = 1'b1;
    resp_n     = 3;
    tick();
    i_wr_valid = 1'b0;
    @(negedge i_clk);
    check("pp_count_same", o_fifo_count, 5);
    check("pp_start", o_tx_start, 1);
    for (int i = 0; i < 40; i++) begin
      resp_n = $urandom_range(1, 8);
      push_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drained(2000);

    // 5. reset while waiting with bytes queued
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    repeat (2) tick();
    check("mid_rst_count_before", o_fifo_count, 3);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    @(negedge i_clk);
    check("mid_rst_count", o_fifo_count, 0);
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_start", o_tx_start, 0);
    repeat (20) tick();

    // 6. stray done in idle and in start is ignored
    pulse_stray_done();
    @(negedge i_clk);
    check("stray_idle_busy", o_busy, 0);
    tick();
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h3E;
    tick();
    i_wr_valid = 1'b0;
    tick();
    check("stray_in_start", o_tx_start, 1);
    pulse_stray_done();
    @(negedge i_clk);
    check("stray_start_busy", o_busy, 1);
    repeat (10) tick();
    check("stray_still_wait", o_busy, 1);
    pulse_stray_done();
    @(negedge i_clk);
    check("stray_final_idle", o_busy, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
